if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'hE1A0_0000, is the bubble encoding placed in the IF/ID register.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 stall_i  input  1  hazard hold; IF/ID register and PC are frozen.
REQ-006 branch_taken_i  input  1  redirect request from a later stage.
REQ-007 branch_target_i  input  32  redirect address, valid while branch_taken_i=1.
REQ-008 imem_req_o  output  1  fetch request to instruction memory.
REQ-009 imem_addr_o  output  32  fetch address; equals the PC register.
REQ-010 imem_ready_i  input  1  memory returns imem_rdata_i this cycle; wait states allowed.
REQ-011 imem_rdata_i  input  32  fetched instruction word.
REQ-012 instr_o  output  32  IF/ID instruction to the decoder.
REQ-013 pc_r_o  output  32  address of instr_o; the decoder derives pc+4 from it.
REQ-014 valid_o  output  1  instr_o is a real instruction, not a bubble.

Function
REQ-015 The block SHALL implement states IDLE, FETCH and HOLD, encoded in a 2-bit register.
REQ-016 IDLE: imem_req_o=0; the block SHALL move unconditionally to FETCH on the next cycle.
REQ-017 FETCH: imem_req_o=1 and imem_addr_o=PC, combinationally.
REQ-018 FETCH, imem_ready_i=1, stall_i=0: IF/ID SHALL load {imem_rdata_i, PC, valid=1}, PC SHALL become PC+4 (mod 2^32), and the state SHALL stay FETCH.
REQ-019 FETCH, imem_ready_i=1, stall_i=1: the word and its PC SHALL be captured into a one-entry skid buffer, and the state SHALL become HOLD. PC and IF/ID SHALL stay unchanged.
REQ-020 FETCH, imem_ready_i=0, stall_i=0: IF/ID SHALL load a bubble {NOP_INSTR, PC, valid=0}, and PC SHALL be held.
REQ-021 FETCH, imem_ready_i=0, stall_i=1: all registers SHALL hold.
REQ-022 HOLD: imem_req_o=0; all registers SHALL hold while stall_i=1.
REQ-023 HOLD, stall_i=0: IF/ID SHALL load the skid buffer contents with valid=1, PC SHALL become PC+4, the buffer SHALL empty, and the state SHALL become FETCH.
REQ-024 branch_taken_i=1 SHALL override stall_i, imem_ready_i and any state:
- PC becomes branch_target_i.
- IF/ID becomes a bubble with pc_r_o=branch_target_i.
- The skid buffer empties.
- The state becomes FETCH.
- Any memory response in the same cycle is discarded.
REQ-025 branch_target_i SHALL be used as-is; bits [1:0] are not checked.
REQ-026 PC increment SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without a flag.
REQ-027 The skid buffer SHALL never hold more than one word; no fetch is issued while it is full.
REQ-028 Latency: a word accepted in cycle N SHALL appear on instr_o in cycle N+1 when not stalled.

Reset
REQ-029 While rst_n_i=0, outputs SHALL be forced asynchronously:
- state=IDLE, PC=RESET_PC, skid buffer empty.
- instr_o=NOP_INSTR, pc_r_o=RESET_PC, valid_o=0, imem_req_o=0.
REQ-030 Reset asserted mid-operation, including in HOLD or during a wait state, SHALL discard all in-flight data.
REQ-031 The first imem_req_o SHALL occur in the second cycle after rst_n_i deasserts, with imem_addr_o=RESET_PC.

Verification
REQ-032 Reset release, imem_ready_i tied 1, words 0xA0,0xA1,0xA2 -> instr_o shows 0xA0,0xA1,0xA2 on consecutive cycles; pc_r_o=0,4,8; valid_o=1.
REQ-033 Two wait cycles (imem_ready_i=0) on address 0x8 -> two bubbles (valid_o=0, instr_o=NOP_INSTR), then the word at 0x8; imem_addr_o stays 0x8 throughout.
REQ-034 stall_i=1 for 3 cycles while the word at 0x10 returns -> state HOLD, imem_req_o=0, instr_o unchanged; after release, instr_o=word(0x10), pc_r_o=0x10, next fetch at 0x14.
REQ-035 branch_taken_i=1 with target 0x200 in the same cycle as stall_i=1 and imem_ready_i=1 -> valid_o=0, pc_r_o=0x200; next imem_addr_o=0x200; the returned word is dropped.
REQ-036 PC=0xFFFF_FFFC, ready -> next imem_addr_o=0x0000_0000.
REQ-037 rst_n_i pulsed low while in HOLD -> outputs return to reset values immediately, without a clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory fetch port shared by the fetch stage (master) and the
// instruction memory or its model (slave).
interface if_stage_if;
   // A fetch completes in any cycle where imem_req_o and imem_ready_i are both
   // high; imem_rdata_i is sampled on that rising edge. Ready without req is ignored.
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ready_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ready_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID register and a one-entry skid
// buffer that parks a returned word while decode is stalled.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             stall_i,
   input  logic             branch_taken_i,
   input  logic [31:0]      branch_target_i,
   if_stage_if.master       imem,
   output logic [31:0]      instr_o,
   output logic [31:0]      pc_r_o,
   output logic             valid_o,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      HOLD  = 2'b10
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] instr_q;
   logic [31:0] pc_r_q;
   logic        valid_q;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc;
   logic        skid_full;

   // Requests are only issued in FETCH, so a full skid buffer (HOLD) never fetches.
   assign imem.imem_req_o  = (state == FETCH);
   assign imem.imem_addr_o = pc;
   assign instr_o          = instr_q;
   assign pc_r_o           = pc_r_q;
   assign valid_o          = valid_q;
   assign state_o          = state;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         instr_q    <= NOP_INSTR;
         pc_r_q     <= RESET_PC;
         valid_q    <= 1'b0;
         skid_instr <= NOP_INSTR;
         skid_pc    <= RESET_PC;
         skid_full  <= 1'b0;
      end else if (branch_taken_i) begin
         // Redirect wins over everything; a same-cycle memory response is dropped.
         state     <= FETCH;
         pc        <= branch_target_i;
         instr_q   <= NOP_INSTR;
         pc_r_q    <= branch_target_i;
         valid_q   <= 1'b0;
         skid_full <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= FETCH;
            end
            FETCH: begin
               if (imem.imem_ready_i && !stall_i) begin
                  instr_q <= imem.imem_rdata_i;
                  pc_r_q  <= pc;
                  valid_q <= 1'b1;
                  pc      <= pc + 32'd4;
               end else if (imem.imem_ready_i && stall_i) begin
                  skid_instr <= imem.imem_rdata_i;
                  skid_pc    <= pc;
                  skid_full  <= 1'b1;
                  state      <= HOLD;
               end else if (!stall_i) begin
                  instr_q <= NOP_INSTR;
                  pc_r_q  <= pc;
                  valid_q <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  instr_q   <= skid_instr;
                  pc_r_q    <= skid_pc;
                  valid_q   <= 1'b1;
                  pc        <= pc + 32'd4;
                  skid_full <= 1'b0;
                  state     <= FETCH;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized bench for if_stage against a cycle-level reference model.
module tb_if_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_HOLD  = 2;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] instr;
   logic [31:0] pc_r;
   logic        valid;
   logic [1:0]  state;

   if_stage_if bus ();

   if_stage #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .stall_i         (stall),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .imem            (bus.master),
      .instr_o         (instr),
      .pc_r_o          (pc_r),
      .valid_o         (valid),
      .state_o         (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state: what the fetch stage should hold after each edge.
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pcr;
   logic        m_valid;
   logic [31:0] m_held_word;
   logic [31:0] m_held_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0000_00A0 + (a >> 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_pc    = RESET_PC;
      m_instr = NOP_INSTR;
      m_pcr   = RESET_PC;
      m_valid = 1'b0;
   endtask

   task automatic model_edge(input logic st, input logic br, input logic [31:0] tgt,
                             input logic rdy);
      if (br) begin
         m_pc = tgt; m_instr = NOP_INSTR; m_pcr = tgt; m_valid = 1'b0; m_mode = M_FETCH;
      end else if (m_mode == M_IDLE) begin
         m_mode = M_FETCH;
      end else if (m_mode == M_FETCH) begin
         if (rdy && !st) begin
            m_instr = mem_word(m_pc); m_pcr = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
         end else if (rdy) begin
            m_held_word = mem_word(m_pc); m_held_pc = m_pc; m_mode = M_HOLD;
         end else if (!st) begin
            m_instr = NOP_INSTR; m_pcr = m_pc; m_valid = 1'b0;
         end
      end else if (!st) begin
         m_instr = m_held_word; m_pcr = m_held_pc; m_valid = 1'b1;
         m_pc = m_pc + 32'd4; m_mode = M_FETCH;
      end
   endtask

   task automatic check_regs();
      chk("instr_o", instr, m_instr);
      chk("pc_r_o", pc_r, m_pcr);
      chk("valid_o", {31'd0, valid}, {31'd0, m_valid});
      chk("state_o", {30'd0, state}, m_mode);
   endtask

   // One clock cycle: drive at negedge, check fetch port, clock, check IF/ID.
   task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                       input logic rdy);
      stall             = st;
      branch_taken      = br;
      branch_target     = tgt;
      bus.imem_ready_i  = rdy;
      bus.imem_rdata_i  = rdy ? mem_word(bus.imem_addr_o) : 32'hDEAD_BEEF;
      #1;
      chk("imem_req_o", {31'd0, bus.imem_req_o}, {31'd0, (m_mode == M_FETCH)});
      chk("imem_addr_o", bus.imem_addr_o, m_pc);
      @(posedge clk);
      model_edge(st, br, tgt, rdy);
      #1;
      check_regs();
      @(negedge clk);
   endtask

   // Pulse reset between edges and check outputs before any clock edge.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_regs();
      chk("rst imem_req_o", {31'd0, bus.imem_req_o}, 32'd0);
      chk("rst imem_addr_o", bus.imem_addr_o, RESET_PC);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n            = 1'b0;
      stall            = 1'b0;
      branch_taken     = 1'b0;
      branch_target    = 32'd0;
      bus.imem_ready_i = 1'b0;
      bus.imem_rdata_i = 32'd0;
      m_held_word      = 32'd0;
      m_held_pc        = 32'd0;
      model_reset();
      repeat (2) @(negedge clk);
      check_regs();
      chk("reset imem_req_o", {31'd0, bus.imem_req_o}, 32'd0);
      rst_n = 1'b1;

      // Release: one idle cycle, then a 3-word stream with two wait states at 0x8.
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("first word", instr, 32'h0000_00A0);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("second pc", pc_r, 32'h4);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("wait bubble", instr, NOP_INSTR);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("word after wait", instr, 32'h0000_00A2);
      step(1'b0, 1'b0, 32'd0, 1'b1);

      // Stall for 3 cycles while the word at 0x10 returns.
      step(1'b1, 1'b0, 32'd0, 1'b1);
      chk("hold keeps instr", instr, 32'h0000_00A3);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("skid pc", pc_r, 32'h10);
      step(1'b0, 1'b0, 32'd0, 1'b1);

      // Branch beats stall and a same-cycle response.
      step(1'b1, 1'b1, 32'h200, 1'b1);
      chk("branch pc_r", pc_r, 32'h200);
      step(1'b0, 1'b0, 32'd0, 1'b1);

      // PC wrap-around, and an unaligned target used as-is.
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b1, 32'h0000_0123, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);

      // Reset while in HOLD, then restart at RESET_PC.
      step(1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b0);
      async_reset();
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);

      // Reset during a wait state.
      step(1'b0, 1'b0, 32'd0, 1'b0);
      async_reset();
      step(1'b0, 1'b0, 32'd0, 1'b1);

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), $urandom,
              ($urandom_range(0, 9) < 7));
         if ($urandom_range(0, 99) == 0) async_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
